// File: rtl/counter_ctrl.sv
// Command sequencer for the dual-edge counter: turns LOAD/RUN/STEP/STOP commands into cen/wen/dat.
// Optional build macro COUNTER_CTRL_STATUS_EN adds the step_left status output.
module counter_ctrl #(
    parameter int WIDTH = 8,
    parameter int PSW   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_vld,
    output logic             cmd_rdy,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic [PSW-1:0]   psc,
    output logic             cen,
    output logic             wen,
    output logic [WIDTH-1:0] dat,
    output logic             busy,
`ifdef COUNTER_CTRL_STATUS_EN
    output logic [WIDTH-1:0] step_left,
`endif
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_STEP} state_t;

    localparam logic [1:0]       OP_LOAD = 2'b00;
    localparam logic [1:0]       OP_RUN  = 2'b01;
    localparam logic [1:0]       OP_STEP = 2'b10;
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PSW-1:0]   ONE_P   = {{(PSW-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic               cen_q, cen_d;
    logic               wen_q, wen_d;
    logic [WIDTH-1:0]   dat_q, dat_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pend_q, pend_d;
    logic [PSW-1:0]     pc_q, pc_d;
    logic [PSW-1:0]     psc_q, psc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;

    logic accept;
    logic tick;

    assign cmd_rdy = (state_q != S_LOAD);
    assign accept  = cmd_vld && cmd_rdy;
    assign tick    = (pc_q == psc_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cen_q   <= 1'b0;
            wen_q   <= 1'b0;
            dat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
            pc_q    <= '0;
            psc_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cen_q   <= cen_d;
            wen_q   <= wen_d;
            dat_q   <= dat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
            pc_q    <= pc_d;
            psc_q   <= psc_d;
            rem_q   <= rem_d;
        end
    end

    // An accepted command always preempts whatever operation is in progress.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (cmd_op)
                OP_LOAD: state_d = S_LOAD;
                OP_RUN:  state_d = S_RUN;
                OP_STEP: state_d = (cmd_arg == '0) ? S_IDLE : S_STEP;
                default: state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_LOAD:  state_d = S_IDLE;
                S_STEP:  if (tick && rem_q <= ONE_W) state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        cen_d  = 1'b0;
        wen_d  = 1'b0;
        dat_d  = dat_q;
        pc_d   = pc_q;
        psc_d  = psc_q;
        rem_d  = rem_q;
        pend_d = 1'b0;
        done_d = pend_q;
        busy_d = (state_d == S_RUN) || (state_d == S_STEP);
        if (accept) begin
            case (cmd_op)
                OP_LOAD: begin
                    wen_d = 1'b1;
                    dat_d = cmd_arg;
                end
                OP_RUN: begin
                    psc_d = psc;
                    pc_d  = '0;
                    rem_d = '0;
                end
                OP_STEP: begin
                    psc_d  = psc;
                    pc_d   = '0;
                    rem_d  = cmd_arg;
                    pend_d = (cmd_arg == '0);
                end
                default: rem_d = '0;
            endcase
        end else if (state_q == S_RUN || state_q == S_STEP) begin
            if (tick) begin
                pc_d  = '0;
                cen_d = 1'b1;
                if (state_q == S_STEP && rem_q != '0) begin
                    rem_d  = rem_q - ONE_W;
                    pend_d = (rem_q == ONE_W);
                end
            end else begin
                pc_d = pc_q + ONE_P;
            end
        end
    end

    assign cen  = cen_q;
    assign wen  = wen_q;
    assign dat  = dat_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef COUNTER_CTRL_STATUS_EN
    assign step_left = (state_q == S_STEP) ? rem_q : '0;
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: a time-based reference model predicts each cycle's outputs.
// Define COUNTER_CTRL_STATUS_EN for both files to also check step_left.
module tb_counter_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_vld;
    logic         cmd_rdy;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_arg;
    logic [7:0]   psc;
    logic         cen, wen, busy, done;
    logic [W-1:0] dat;
    logic [W-1:0] left_w;

    always #5 clk = ~clk;

    counter_ctrl #(.WIDTH(W), .PSW(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .psc(psc), .cen(cen), .wen(wen),
        .dat(dat), .busy(busy),
`ifdef COUNTER_CTRL_STATUS_EN
        .step_left(left_w),
`endif
        .done(done)
    );
`ifndef COUNTER_CTRL_STATUS_EN
    assign left_w = '0;
`endif

    typedef struct packed {
        logic         rdy;
        logic         cen;
        logic         wen;
        logic         busy;
        logic         done;
        logic [W-1:0] dat;
        logic [W-1:0] left;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Model: an operation is described by its acceptance edge, tick period and step count;
    // outputs follow from the number of edges elapsed since acceptance.
    int           t = 0;
    int           mode = 0;     // 0 idle, 1 run, 2 step
    int           acc_t = 0;
    int           per = 1;
    int           nstep = 0;
    int           cur_done = -1;
    int           prev_done = -1;
    int           load_at = -1;
    logic [W-1:0] dat_m = '0;

    task automatic model_reset();
        mode = 0; cur_done = -1; prev_done = -1; load_at = -1; dat_m = '0;
    endtask

    task automatic model_edge();
        bit   rdy_prev, acc;
        int   k;
        exp_t e;
        rdy_prev = (load_at != t);
        t++;
        acc = cmd_vld && rdy_prev;
        if (acc) begin
            if (cur_done > t) cur_done = -1;
            else prev_done = cur_done;
            cur_done = -1;
            case (cmd_op)
                2'd0: begin mode = 0; load_at = t; dat_m = cmd_arg; end
                2'd1: begin mode = 1; acc_t = t; per = int'(psc) + 1; end
                2'd2: begin
                    mode = 2; acc_t = t; per = int'(psc) + 1; nstep = int'(cmd_arg);
                    cur_done = t + nstep * per + 1;
                end
                default: mode = 0;
            endcase
        end
        k = t - acc_t;
        e.rdy  = (load_at != t);
        e.wen  = (load_at == t);
        e.dat  = dat_m;
        e.cen  = (mode == 1 && k > 0 && k % per == 0) ||
                 (mode == 2 && k > 0 && k % per == 0 && k <= nstep * per);
        e.busy = (mode == 1) || (mode == 2 && k < nstep * per);
        e.done = (cur_done == t) || (prev_done == t);
`ifdef COUNTER_CTRL_STATUS_EN
        e.left = (mode == 2 && k < nstep * per) ? W'(nstep - k / per) : '0;
`else
        e.left = '0;
`endif
        q.push_back(e);
    endtask

    task automatic cyc(input bit v, input int o, input int a, input int p);
        cmd_vld = v;
        cmd_op  = o[1:0];
        cmd_arg = a[W-1:0];
        psc     = p[7:0];
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, $urandom_range(3), $urandom_range(255), $urandom_range(255));
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({cmd_rdy, cen, wen, busy, done, dat, left_w} !== {1'b1, 4'b0, {W{1'b0}}, {W{1'b0}}}) begin
            errors++;
            $display("FAIL %s: rdy=%b cen=%b wen=%b busy=%b done=%b dat=%h left=%h, want rdy=1 others 0",
                     name, cmd_rdy, cen, wen, busy, done, dat, left_w);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_op");
        model_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e, a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {cmd_rdy, cen, wen, busy, done, dat, left_w};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle t=%0d: got rdy=%b cen=%b wen=%b busy=%b done=%b dat=%h left=%h; want rdy=%b cen=%b wen=%b busy=%b done=%b dat=%h left=%h",
                         t, a.rdy, a.cen, a.wen, a.busy, a.done, a.dat, a.left,
                         e.rdy, e.cen, e.wen, e.busy, e.done, e.dat, e.left);
            end
            checks++;
            if (cen && wen) begin
                errors++;
                $display("FAIL cen_wen_exclusive: got cen=%b wen=%b, want not both 1", cen, wen);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d want 0", q.size());
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n = 1'b0; cmd_vld = 1'b0; cmd_op = 2'd0; cmd_arg = '0; psc = '0;
        #12;
        check_reset_outputs("reset_initial");
        #10;
        rst_n = 1'b1;

        // LOAD 0xA5
        cyc(1'b1, 0, 'hA5, 0);
        cyc(1'b1, 3, 0, 0);         // offered while not ready: must be ignored
        idle(3);
        // RUN psc=3, then STOP
        cyc(1'b1, 1, 0, 3);
        idle(13);
        cyc(1'b1, 3, 0, 0);
        idle(6);
        // STEP 5 at psc=0, then STEP 0
        cyc(1'b1, 2, 5, 0);
        idle(8);
        cyc(1'b1, 2, 0, 0);
        idle(3);
        // STEP 10 at psc=1 preempted by LOAD after the third tick
        cyc(1'b1, 2, 10, 1);
        idle(6);
        cyc(1'b1, 0, 'h3C, 0);
        idle(6);
        // STEP 4 at psc=2 (step_left countdown)
        cyc(1'b1, 2, 4, 2);
        idle(15);
        // Reset in the middle of a RUN
        cyc(1'b1, 1, 0, 1);
        idle(5);
        do_reset();
        idle(3);
        // STEP finishing just before a new command is accepted
        cyc(1'b1, 2, 2, 0);
        idle(2);
        cyc(1'b1, 2, 0, 0);
        idle(4);

        // Randomized command stream
        for (int i = 0; i < 3000; i++) begin
            int a, p;
            a = ($urandom_range(7) == 0) ? 0 : $urandom_range(1, 9);
            p = ($urandom_range(5) == 0) ? $urandom_range(4, 9) : $urandom_range(3);
            cyc($urandom_range(9) < 2, $urandom_range(3), a, p);
            if (i == 1500) do_reset();
        end

        cmd_vld = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
